// File: rtl/bram_window.sv
// Pixel RAM with byte-lane writes plus a 3x3 neighbourhood fetch engine that shares the single port.
// "do" is a reserved word in SystemVerilog, so the external read-data port is named do_data.
module bram_window #(
    parameter int IMG_WIDTH  = 205,
    parameter int IMG_HEIGHT = 308,
    parameter int SIZE       = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_WIDTH = 16,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 9,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 3,
    parameter int READ_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NB_COL-1:0]             we,
    input  logic                          re,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   di,
    output logic [NB_COL*COL_WIDTH-1:0]   do_data,
    output logic                          do_valid,
    output logic                          busy,
    input  logic                          win_req,
    input  logic [X_WIDTH-1:0]            win_x,
    input  logic [Y_WIDTH-1:0]            win_y,
    output logic                          win_valid,
    input  logic                          win_ack,
    output logic                          win_oob,
    output logic [9*NB_COL*COL_WIDTH-1:0] win_data
);

    localparam int P     = NB_COL * COL_WIDTH;
    localparam int W     = 9 * P;
    localparam int IDX_W = $clog2(SIZE);
    localparam logic [ADDR_WIDTH:0]   SIZE_A  = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [X_WIDTH:0]      IMG_W_X = (X_WIDTH + 1)'(IMG_WIDTH);
    localparam logic [Y_WIDTH:0]      IMG_H_Y = (Y_WIDTH + 1)'(IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_A = ADDR_WIDTH'(IMG_WIDTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [P-1:0] mem [SIZE];

    logic [3:0]            k_q, k_d;
    logic [X_WIDTH-1:0]    x_q, x_d;
    logic [Y_WIDTH-1:0]    y_q, y_d;
    logic                  win_oob_q, win_oob_d;
    logic                  iss_vld_q, iss_vld_d;
    logic                  iss_pad_q, iss_pad_d;
    logic [3:0]            iss_slot_q, iss_slot_d;
    logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [3:0]            rd_slot_q, rd_slot_d;
    logic [P-1:0]          rd_data_q, rd_data_d;
    logic [P-1:0]          do_data_q, do_data_d;
    logic                  do_valid_q, do_valid_d;
    logic                  win_valid_q, win_valid_d;
    logic [W-1:0]          win_data_q, win_data_d;

    logic                  accept;
    logic                  fetching;
    logic                  slot8_landed;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_in_range;
    logic [P-1:0]          ram_word;
    logic [NB_COL-1:0]     mem_we;
    logic [1:0]            dxm, dym;
    logic [X_WIDTH:0]      cx;
    logic [Y_WIDTH:0]      cy;
    logic                  slot_pad;
    logic [ADDR_WIDTH-1:0] slot_addr;

    // The engine owns the port whenever busy, so one address mux serves both users.
    always_comb begin
        ram_addr     = busy ? iss_addr_q : addr;
        ram_in_range = ({1'b0, ram_addr} < SIZE_A);
        ram_word     = ram_in_range ? mem[ram_addr[IDX_W-1:0]] : '0;
        mem_we       = (busy || !ram_in_range) ? '0 : we;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_COL; i++) begin
            if (mem_we[i]) begin
                mem[ram_addr[IDX_W-1:0]][i*COL_WIDTH +: COL_WIDTH] <= di[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_req)            state_d = FETCH;
            FETCH:   if (k_q == 4'd8)        state_d = DRAIN;
            DRAIN:   if (slot8_landed)       state_d = DONE;
            DONE:    if (win_ack)            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        accept       = (state_q == IDLE) && win_req;
        fetching     = (state_q == FETCH);
        slot8_landed = rd_vld_q && (rd_slot_q == 4'd8);
    end

    // Slot k sits at offset (k mod 3 - 1, k / 3 - 1); the extra top bit catches -1 and overflow.
    always_comb begin
        unique case (k_q)
            4'd0, 4'd3, 4'd6: dxm = 2'd0;
            4'd1, 4'd4, 4'd7: dxm = 2'd1;
            default:          dxm = 2'd2;
        endcase
        unique case (k_q)
            4'd0, 4'd1, 4'd2: dym = 2'd0;
            4'd3, 4'd4, 4'd5: dym = 2'd1;
            default:          dym = 2'd2;
        endcase
        cx        = {1'b0, x_q} + (X_WIDTH + 1)'(dxm) - (X_WIDTH + 1)'(1);
        cy        = {1'b0, y_q} + (Y_WIDTH + 1)'(dym) - (Y_WIDTH + 1)'(1);
        slot_pad  = cx[X_WIDTH] || (cx >= IMG_W_X) || cy[Y_WIDTH] || (cy >= IMG_H_Y);
        slot_addr = ADDR_WIDTH'(cy) * IMG_W_A + ADDR_WIDTH'(cx);
    end

    always_comb begin
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        win_oob_d   = win_oob_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;

        if (accept) begin
            x_d         = win_x;
            y_d         = win_y;
            win_oob_d   = ({1'b0, win_x} >= IMG_W_X) || ({1'b0, win_y} >= IMG_H_Y);
            win_valid_d = 1'b0;
            k_d         = 4'd0;
        end
        if (fetching) begin
            k_d = k_q + 4'd1;
        end

        iss_vld_d  = fetching;
        iss_slot_d = k_q;
        iss_pad_d  = win_oob_q || slot_pad;
        iss_addr_d = slot_addr;

        // Padded slots never touch the RAM result; the flag rides along with the read.
        rd_vld_d  = iss_vld_q;
        rd_slot_d = iss_slot_q;
        rd_data_d = iss_pad_q ? '0 : ram_word;

        for (int s = 0; s < 9; s++) begin
            if (rd_vld_q && (rd_slot_q == 4'(s))) begin
                win_data_d[s*P +: P] = rd_data_q;
            end
        end
        if ((state_q == DRAIN) && slot8_landed) begin
            win_valid_d = 1'b1;
        end
        if ((state_q == DONE) && win_ack) begin
            win_valid_d = 1'b0;
        end

        do_valid_d = re && !busy;
        do_data_d  = do_data_q;
        if (do_valid_d) begin
            do_data_d = ram_word;
            if ((READ_MODE == 1) && ram_in_range) begin
                for (int i = 0; i < NB_COL; i++) begin
                    if (we[i]) begin
                        do_data_d[i*COL_WIDTH +: COL_WIDTH] = di[i*COL_WIDTH +: COL_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            win_oob_q   <= 1'b0;
            iss_vld_q   <= 1'b0;
            iss_pad_q   <= 1'b0;
            iss_slot_q  <= '0;
            iss_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            rd_slot_q   <= '0;
            rd_data_q   <= '0;
            do_data_q   <= '0;
            do_valid_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
        end else begin
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            win_oob_q   <= win_oob_d;
            iss_vld_q   <= iss_vld_d;
            iss_pad_q   <= iss_pad_d;
            iss_slot_q  <= iss_slot_d;
            iss_addr_q  <= iss_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_slot_q   <= rd_slot_d;
            rd_data_q   <= rd_data_d;
            do_data_q   <= do_data_d;
            do_valid_q  <= do_valid_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
        end
    end

    assign do_data   = do_data_q;
    assign do_valid  = do_valid_q;
    assign win_valid = win_valid_q;
    assign win_oob   = win_oob_q;
    assign win_data  = win_data_q;

endmodule

// File: tb/tb_bram_window.sv
// Bench for bram_window on a 4x3 image: read-first and write-first instances share one stimulus.
// Reads and windows are scoreboarded through queues filled when stimulus is driven.
module tb_bram_window;

    localparam int IW = 4;
    localparam int IH = 3;
    localparam int SZ = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    we = '0;
    logic          re = 1'b0;
    logic [15:0]   addr = '0;
    logic [23:0]   di = '0;
    logic          win_req = 1'b0;
    logic [7:0]    win_x = '0;
    logic [8:0]    win_y = '0;
    logic          win_ack = 1'b0;

    logic [23:0]   do0, do1;
    logic          dv0, dv1, busy0, busy1, wv0, wv1, oob0, oob1;
    logic [215:0]  wd0, wd1;

    always #5 clk = ~clk;

    bram_window #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .SIZE(SZ), .READ_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .di(di),
        .do_data(do0), .do_valid(dv0), .busy(busy0),
        .win_req(win_req), .win_x(win_x), .win_y(win_y), .win_valid(wv0),
        .win_ack(win_ack), .win_oob(oob0), .win_data(wd0)
    );

    bram_window #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .SIZE(SZ), .READ_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .di(di),
        .do_data(do1), .do_valid(dv1), .busy(busy1),
        .win_req(win_req), .win_x(win_x), .win_y(win_y), .win_valid(wv1),
        .win_ack(win_ack), .win_oob(oob1), .win_data(wd1)
    );

    typedef struct {
        string       name;
        logic [2:0]  we;
        logic        re;
        logic [15:0] addr;
        logic [23:0] di;
        logic [23:0] exp0;
        logic [23:0] exp1;
    } vec_t;

    vec_t         vecs [14];
    logic [23:0]  rq0 [$];
    logic [23:0]  rq1 [$];
    logic [216:0] wq [$];
    logic [23:0]  last0 = '0;
    logic [23:0]  last1 = '0;
    int           tests = 0;
    int           fails = 0;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        tests++;
        fails++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    function automatic logic [216:0] exp_window(input int x, input int y);
        logic [215:0] d;
        logic         oob;
        int           cx, cy;
        d   = '0;
        oob = (x >= IW) || (y >= IH);
        for (int k = 0; k < 9; k++) begin
            cx = x + (k % 3) - 1;
            cy = y + (k / 3) - 1;
            if (!oob && cx >= 0 && cx < IW && cy >= 0 && cy < IH) begin
                d[k*24 +: 24] = 24'(cy * IW + cx) * 24'h010101;
            end
        end
        return {oob, d};
    endfunction

    // One external access cycle; the expected read word is queued as the access is driven.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        we   = v.we;
        re   = v.re;
        addr = v.addr;
        di   = v.di;
        if (v.re) begin
            rq0.push_back(v.exp0);
            rq1.push_back(v.exp1);
        end
        @(posedge clk);
        #1;
        we = '0;
        re = 1'b0;
        check_output({v.name, " do_valid m0"}, dv0, v.re);
        check_output({v.name, " do_valid m1"}, dv1, v.re);
        if (dv0) begin
            if (rq0.size() == 0) fail_now({v.name, " m0"}, "read with empty scoreboard");
            else begin
                last0 = rq0.pop_front();
                check_output({v.name, " do m0"}, do0, last0);
            end
        end else begin
            check_output({v.name, " do hold m0"}, do0, last0);
        end
        if (dv1) begin
            if (rq1.size() == 0) fail_now({v.name, " m1"}, "read with empty scoreboard");
            else begin
                last1 = rq1.pop_front();
                check_output({v.name, " do m1"}, do1, last1);
            end
        end else begin
            check_output({v.name, " do hold m1"}, do1, last1);
        end
    endtask

    task automatic preload();
        for (int a = 0; a < SZ; a++) begin
            @(negedge clk);
            we   = 3'b111;
            addr = 16'(a);
            di   = 24'(a) * 24'h010101;
        end
        @(negedge clk);
        we = '0;
    endtask

    task automatic run_window(input int x, input int y, input bit poke, input string name);
        logic [216:0] exp;
        int           lat;
        @(negedge clk);
        win_req = 1'b1;
        win_x   = 8'(x);
        win_y   = 9'(y);
        wq.push_back(exp_window(x, y));
        @(posedge clk);
        #1;
        win_req = 1'b0;
        check_output({name, " busy after accept"}, busy0, 1'b1);
        check_output({name, " valid cleared"}, wv0, 1'b0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            check_output({name, " no do_valid while busy"}, dv0, 1'b0);
            if (wv0) break;
            if (poke && lat >= 1 && lat <= 3) begin
                we   = 3'b111;
                re   = 1'b1;
                addr = 16'd0;
                di   = 24'hFFFFFF;
            end else begin
                we = '0;
                re = 1'b0;
            end
        end
        we = '0;
        re = 1'b0;
        if (!wv0) begin
            fail_now({name, " win_valid"}, "timeout after 40 cycles");
            return;
        end
        check_output({name, " latency"}, lat, 11);
        exp = wq.pop_front();
        check_output({name, " window"}, {oob0, wd0}, exp);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            win_req = (i == 1);
            win_x   = '0;
            win_y   = '0;
            @(posedge clk);
            #1;
            check_output({name, " valid hold"}, wv0, 1'b1);
            check_output({name, " data hold"}, {oob0, wd0}, exp);
        end
        @(negedge clk);
        win_req = 1'b0;
        win_ack = 1'b1;
        @(posedge clk);
        #1;
        win_ack = 1'b0;
        check_output({name, " valid after ack"}, wv0, 1'b0);
        check_output({name, " idle after ack"}, busy0, 1'b0);
        @(posedge clk);
        #1;
        check_output({name, " still idle"}, busy0, 1'b0);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{"wr5",        3'b111, 1'b0, 16'd5,  24'h0A0B0C, 24'h0,      24'h0};
        vecs[1]  = '{"rd5",        3'b000, 1'b1, 16'd5,  24'h0,      24'h0A0B0C, 24'h0A0B0C};
        vecs[2]  = '{"idle",       3'b000, 1'b0, 16'd0,  24'h0,      24'h0,      24'h0};
        vecs[3]  = '{"wr5 ch1",    3'b010, 1'b0, 16'd5,  24'hFFFFFF, 24'h0,      24'h0};
        vecs[4]  = '{"rd5 lane",   3'b000, 1'b1, 16'd5,  24'h0,      24'h0AFF0C, 24'h0AFF0C};
        vecs[5]  = '{"coll2",      3'b111, 1'b1, 16'd2,  24'h123456, 24'h020202, 24'h123456};
        vecs[6]  = '{"rd2",        3'b000, 1'b1, 16'd2,  24'h0,      24'h123456, 24'h123456};
        vecs[7]  = '{"coll7 ch0",  3'b001, 1'b1, 16'd7,  24'h0000AA, 24'h070707, 24'h0707AA};
        vecs[8]  = '{"rd7",        3'b000, 1'b1, 16'd7,  24'h0,      24'h0707AA, 24'h0707AA};
        vecs[9]  = '{"coll12 oor", 3'b111, 1'b1, 16'd12, 24'hABCDEF, 24'h0,      24'h0};
        vecs[10] = '{"rd12 oor",   3'b000, 1'b1, 16'd12, 24'h0,      24'h0,      24'h0};
        vecs[11] = '{"rd11",       3'b000, 1'b1, 16'd11, 24'h0,      24'h0B0B0B, 24'h0B0B0B};
        vecs[12] = '{"wr3 ch2",    3'b100, 1'b0, 16'd3,  24'h550000, 24'h0,      24'h0};
        vecs[13] = '{"rd3",        3'b000, 1'b1, 16'd3,  24'h0,      24'h550303, 24'h550303};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset do", do0, 24'h0);
        check_output("reset do_valid", dv0, 1'b0);
        check_output("reset busy", busy0, 1'b0);
        check_output("reset win_valid", wv0, 1'b0);
        check_output("reset win_oob", oob0, 1'b0);
        check_output("reset win_data", wd0, 216'h0);
        @(negedge clk);
        rst_n = 1'b1;

        preload();
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i]);
        end

        preload();
        run_window(1, 1, 1'b0, "win(1,1)");
        run_window(0, 0, 1'b0, "win(0,0)");
        run_window(4, 0, 1'b0, "win(4,0) oob");
        run_window(3, 2, 1'b0, "win(3,2)");
        run_window(1, 1, 1'b1, "win(1,1) poke");

        v = '{"rd0 after poke", 3'b000, 1'b1, 16'd0, 24'h0, 24'h000000, 24'h000000};
        apply_stimulus(v);
        v = '{"rd5 reload", 3'b000, 1'b1, 16'd5, 24'h0, 24'h050505, 24'h050505};
        apply_stimulus(v);

        @(negedge clk);
        win_req = 1'b1;
        win_x   = 8'd1;
        win_y   = 9'd1;
        @(posedge clk);
        #1;
        win_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("abort busy before reset", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("abort busy", busy0, 1'b0);
        check_output("abort win_valid", wv0, 1'b0);
        check_output("abort win_data", wd0, 216'h0);
        check_output("abort do", do0, 24'h0);
        last0 = '0;
        last1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_window(1, 1, 1'b0, "win(1,1) after abort");

        check_output("read scoreboard drained", rq0.size(), 0);
        check_output("window scoreboard drained", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
